// File: rtl/clock_generation.sv
// Programmable I/O clock generator.
// Produces io_clk from the system clock with a half period of H sys cycles,
// mid-phase and end-of-phase strobes, optional fixed-length bursts and a
// clean stop that always leaves io_clk parked at the configured idle level.

package common_p;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom;
endpackage

module clock_generation #(
    parameter int COUNTER_WIDTH = 16,
    parameter int BURST_WIDTH   = 8
) (
    input  common_p::clk_dom          sys_dom_i,
    input  logic                      clock_enable_i,
    input  logic                      idle_level_i,
    input  logic [COUNTER_WIDTH-1:0]  half_rate_target_i,
    input  logic [COUNTER_WIDTH-1:0]  quarter_rate_target_i,
    input  logic [BURST_WIDTH-1:0]    burst_len_i,
    output logic                      io_clk_o,
    output logic                      half_rate_elapsed_o,
    output logic                      quarter_rate_elapsed_o,
    output logic                      clock_active_o,
    output logic                      burst_done_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } state_e;

    logic clk;
    logic rst_n;

    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    state_e                   state_q,   state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q,     cnt_d;
    logic [COUNTER_WIDTH-1:0] h_q,       h_d;
    logic [COUNTER_WIDTH-1:0] q_q,       q_d;
    logic                     q_valid_q, q_valid_d;
    logic                     idle_q,    idle_d;
    logic [BURST_WIDTH-1:0]   burst_q,   burst_d;
    logic [BURST_WIDTH-1:0]   edges_q,   edges_d;
    logic                     lock_q,    lock_d;
    logic                     io_clk_q,  io_clk_d;
    logic                     half_q,    half_d;
    logic                     quarter_q, quarter_d;
    logic                     active_q,  active_d;
    logic                     done_q,    done_d;

    logic                     phase_end;
    logic [COUNTER_WIDTH-1:0] h_clamped;

    assign phase_end = (cnt_q == h_q);
    assign h_clamped = (half_rate_target_i < COUNTER_WIDTH'(2)) ? COUNTER_WIDTH'(2)
                                                                 : half_rate_target_i;

    // Next-state logic: phase counting, io_clk toggling, burst accounting and
    // the strobe outputs, which are computed for the cycle about to begin.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        h_d       = h_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        idle_d    = idle_q;
        burst_d   = burst_q;
        edges_d   = edges_q;
        lock_d    = lock_q;
        io_clk_d  = io_clk_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                io_clk_d = idle_level_i;
                if (!clock_enable_i) begin
                    lock_d = 1'b0;
                end
                if (clock_enable_i && !lock_q) begin
                    state_d   = RUNNING;
                    cnt_d     = COUNTER_WIDTH'(1);
                    h_d       = h_clamped;
                    q_d       = quarter_rate_target_i;
                    q_valid_d = (quarter_rate_target_i != '0) &&
                                (quarter_rate_target_i < h_clamped);
                    idle_d    = idle_level_i;
                    burst_d   = burst_len_i;
                    edges_d   = '0;
                end
            end
            RUNNING: begin
                if (phase_end) begin
                    cnt_d    = COUNTER_WIDTH'(1);
                    io_clk_d = ~io_clk_q;
                    if (!io_clk_q) begin
                        edges_d = edges_q + BURST_WIDTH'(1);
                        if ((burst_q != '0) && (edges_d == burst_q)) begin
                            state_d = STOPPING;
                            lock_d  = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                end
                if (!clock_enable_i) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (phase_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = lock_q;
                    if (io_clk_q != idle_q) begin
                        io_clk_d = idle_q;
                    end
                end else begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                    if (clock_enable_i && !lock_q) begin
                        state_d = RUNNING;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        active_d  = (state_d != IDLE);
        half_d    = active_d && (cnt_d == h_d) &&
                    !((state_d == STOPPING) && (io_clk_d == idle_d));
        quarter_d = active_d && q_valid_d && (cnt_d == q_d);
    end

    // State and output registers; reset parks everything low and in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            h_q       <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            idle_q    <= 1'b0;
            burst_q   <= '0;
            edges_q   <= '0;
            lock_q    <= 1'b0;
            io_clk_q  <= 1'b0;
            half_q    <= 1'b0;
            quarter_q <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            h_q       <= h_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            idle_q    <= idle_d;
            burst_q   <= burst_d;
            edges_q   <= edges_d;
            lock_q    <= lock_d;
            io_clk_q  <= io_clk_d;
            half_q    <= half_d;
            quarter_q <= quarter_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign io_clk_o               = io_clk_q;
    assign half_rate_elapsed_o    = half_q;
    assign quarter_rate_elapsed_o = quarter_q;
    assign clock_active_o         = active_q;
    assign burst_done_o           = done_q;

endmodule

// File: tb/tb_clock_generation.sv
// Directed bench for clock_generation. Each check compares the packed vector
// {io_clk, half, quarter, active, burst_done} against a hand-derived value.

module tb_clock_generation;

    localparam int CW = 16;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              idleLevel;
    logic [CW-1:0]     halfTarget;
    logic [CW-1:0]     quarterTarget;
    logic [BW-1:0]     burstLen;
    logic              ioClk;
    logic              halfPulse;
    logic              quarterPulse;
    logic              active;
    logic              burstDone;
    common_p::clk_dom  sysDom;

    int assertCount = 0;
    int failCount   = 0;

    assign sysDom = {clk, rst_n};

    clock_generation #(
        .COUNTER_WIDTH (CW),
        .BURST_WIDTH   (BW)
    ) dut (
        .sys_dom_i              (sysDom),
        .clock_enable_i         (enable),
        .idle_level_i           (idleLevel),
        .half_rate_target_i     (halfTarget),
        .quarter_rate_target_i  (quarterTarget),
        .burst_len_i            (burstLen),
        .io_clk_o               (ioClk),
        .half_rate_elapsed_o    (halfPulse),
        .quarter_rate_elapsed_o (quarterPulse),
        .clock_active_o         (active),
        .burst_done_o           (burstDone)
    );

    // 10-unit system clock
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic idle, input int h,
                                 input int q, input int burst);
        enable        = en;
        idleLevel     = idle;
        halfTarget    = CW'(h);
        quarterTarget = CW'(q);
        burstLen      = BW'(burst);
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {ioClk, halfPulse, quarterPulse, active, burstDone};
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] expStopActive [1:9];
    logic [4:0] expBurst      [1:16];

    initial begin
        int cnt;
        logic io;

        expStopActive = '{5'b10010, 5'b10010, 5'b10010, 5'b11010, 5'b00010,
                          5'b00010, 5'b00010, 5'b01010, 5'b10000};
        expBurst = '{5'b00110, 5'b00010, 5'b01010, 5'b10110, 5'b10010, 5'b11010,
                     5'b00110, 5'b00010, 5'b01010, 5'b10110, 5'b10010, 5'b11010,
                     5'b00001, 5'b00000, 5'b00000, 5'b00000};

        // Reset state, idle level not yet sampled
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 4, 2, 0);
        #1 checkOutput("reset_t1", 5'b00000);
        step();
        checkOutput("reset_edge1", 5'b00000);
        step();
        checkOutput("reset_edge2", 5'b00000);
        #2 rst_n = 1'b1;
        step();
        checkOutput("idle_level_hi", 5'b10000);
        applyStimulus(1'b0, 1'b0, 4, 2, 0);
        step();
        checkOutput("idle_level_lo", 5'b00000);

        // Free-run H=4 Q=2
        applyStimulus(1'b1, 1'b0, 4, 2, 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            cnt = ((k - 1) % 4) + 1;
            io  = ((((k - 1) / 4) % 2) == 1);
            checkOutput($sformatf("free_k%0d", k),
                        {io, (cnt == 4), (cnt == 2), 1'b1, 1'b0});
        end
        step();
        checkOutput("free_k17", 5'b00010);

        // Stop during low phase with idle=0: half pulse suppressed
        applyStimulus(1'b0, 1'b0, 4, 2, 0);
        step();
        checkOutput("stopidle_k18", 5'b00110);
        step();
        checkOutput("stopidle_k19", 5'b00010);
        step();
        checkOutput("stopidle_k20", 5'b00010);
        step();
        checkOutput("stopidle_k21", 5'b00000);

        // Stop during low phase with idle=1: half pulse and return to 1; Q=0
        applyStimulus(1'b1, 1'b1, 4, 0, 0);
        for (int m = 1; m <= 9; m++) begin
            step();
            checkOutput($sformatf("stopactive_m%0d", m), expStopActive[m]);
            if (m == 6) applyStimulus(1'b0, 1'b1, 4, 0, 0);
        end

        // Burst of 2 with H=3 Q=1, enable held; H change mid-run ignored
        applyStimulus(1'b1, 1'b0, 3, 1, 2);
        for (int b = 1; b <= 16; b++) begin
            step();
            checkOutput($sformatf("burst_b%0d", b), expBurst[b]);
            if (b == 4) applyStimulus(1'b1, 1'b0, 7, 1, 2);
        end
        applyStimulus(1'b0, 1'b0, 0, 5, 4);
        step();
        checkOutput("burst_relock_b17", 5'b00000);

        // Clamp H=0 -> 2, Q=5 invalid; burst=4 latched
        applyStimulus(1'b1, 1'b0, 0, 5, 4);
        for (int c = 1; c <= 9; c++) begin
            step();
            io = ((((c - 1) / 2) % 2) == 1);
            checkOutput($sformatf("clamp_c%0d", c),
                        {io, ((c % 2) == 0), 1'b0, 1'b1, 1'b0});
            if (c == 1) applyStimulus(1'b1, 1'b0, 10, 5, 4);
        end

        // Asynchronous reset mid-burst
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_now", 5'b00000);
        step();
        checkOutput("async_reset_edge1", 5'b00000);
        step();
        checkOutput("async_reset_edge2", 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
